mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single shared memory port of the MIPS core.
- Port 0 is instruction fetch; port 1 is data load/store.
- Grants one requester at a time and registers that requester's address, write enable and write data toward memory.
- Drives `sel` for the external 2:1 address/data mux and routes read data and completion back to the winner.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 (fetch) request, read-only.
- addr0  in  AW  port 0 address.
- req1  in  1  port 1 (data) request.
- addr1  in  AW  port 1 address.
- we1  in  1  port 1 write enable (1 = store).
- wdata1  in  DW  port 1 store data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted.
- gnt1  out  1  one-cycle pulse: port 1 request accepted.
- done0  out  1  one-cycle pulse: port 0 transaction complete, rdata valid.
- done1  out  1  one-cycle pulse: port 1 transaction complete, rdata valid for loads.
- rdata  out  DW  registered read data, shared by both ports.
- sel  out  1  mux select toward memory (0 = port 0, 1 = port 1); held for the whole transaction.
- mem_req  out  1  memory request, held until accepted.
- mem_addr  out  AW  captured address.
- mem_we  out  1  captured write enable (always 0 for port 0).
- mem_wdata  out  DW  captured store data.
- mem_ready  in  1  memory completion strobe.
- mem_rdata  in  DW  memory read data, valid with mem_ready.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - All outputs 0.
  - FSM in IDLE.
  - last_winner = 1, so port 0 wins the first tie.
- Reset mid-transaction abandons the transaction; no done is issued.
- FSM states: IDLE, BUSY.
- IDLE, cycle N, with req0 or req1 high:
  - Arbitrate and pick a winner.
  - At edge N+1:
    - Capture the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata.
    - sel <= winner, mem_req <= 1, gntX <= 1 for one cycle.
    - last_winner <= winner; state -> BUSY.
- IDLE with no request: outputs hold; mem_req stays 0.
- BUSY:
  - mem_req, mem_addr, mem_we, mem_wdata and sel stay stable.
  - Requester inputs are ignored.
- BUSY, mem_ready sampled high at edge M:
  - doneX <= 1 (pulse); rdata <= mem_rdata.
  - mem_req <= 0; state -> IDLE.
  - For writes, rdata is still loaded and must be ignored by the requester.
- mem_ready in IDLE is ignored.
- Latency:
  - req -> mem_req: 1 cycle.
  - mem_ready -> done: 1 cycle.
  - At least one IDLE cycle between back-to-back transactions.
  - Minimum per-transaction time: 3 cycles with zero-wait memory.
- Handshake:
  - A requester holds req and its fields stable until it sees gnt.
  - After gnt it may drop or change req; captured fields are unaffected.
  - A req still high after done is treated as a new request.
  - A req dropped before gnt is discarded silently.
- Arbitration on simultaneous req0 and req1: see Optional Feature.
- Single requester always wins.
- sel changes only on the edge where a grant is issued. It keeps its last value while IDLE.
- No width conversion: addresses and data pass through unchanged.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On a tie, the winner is the port not equal to last_winner (alternates 0,1,0,1).
  - Guarantees each port a grant within two transactions.
- Undefined:
  - Fixed priority: port 1 (data) always wins ties.
  - last_winner is still tracked but unused for decisions.
  - Port 0 may starve while req1 is held continuously.

Test Plan:
- Reset: drive rst_n=0 mid-BUSY with mem_req=1 -> all outputs 0 immediately (asynchronously); after release, req0 alone, addr0=0x00400000 -> gnt0 and mem_req high next cycle, mem_addr=0x00400000, sel=0.
- Single read: req1=1, we1=0, addr1=0x10010004; mem_ready asserted 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> done1 pulse one cycle later, rdata=0xDEADBEEF, done0 stays 0.
- Store: req1=1, we1=1, wdata1=0x12345678, addr1=0x10010008 -> mem_we=1, mem_wdata=0x12345678, sel=1 stable until mem_ready; done1 pulse.
- Tie, four back-to-back transactions with req0 and req1 held high and zero-wait mem_ready:
  - With ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
  - Without it: 1,1,1,1.
- Stability: change addr1/wdata1 every cycle while BUSY -> mem_addr/mem_wdata unchanged; spurious mem_ready while IDLE -> no done pulse, no state change.
- Dropped request: req0 high one cycle during BUSY (port 1 transaction), then low -> no gnt0 issued after return to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester, grant/completion and memory-side signals of the
// shared MIPS memory port. The slave modport is the arbiter's view. The
// master modport is the surrounding system: both requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0: instruction fetch (read-only)
  logic          req0;
  logic [AW-1:0] addr0;
  // Port 1: data load/store
  logic          req1;
  logic [AW-1:0] addr1;
  logic          we1;
  logic [DW-1:0] wdata1;
  // Grants, completions and shared read data
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  // Memory side
  logic          sel;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, mem_ready, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
           sel, mem_req, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, mem_ready, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
           sel, mem_req, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single shared memory port.
// Port 0 is instruction fetch (read-only) and port 1 is data load/store.
// One transaction is in flight at a time. The winner's address, write enable
// and store data are registered toward memory. sel steers the external 2:1
// mux. Read data and a completion pulse are returned to the winner.
//
// Build option ARB_ROUND_ROBIN_EN:
//   defined   - ties alternate, so the loser of the last grant wins the next tie
//   undefined - ties go to port 1 (data). Port 0 can starve while req1 is held.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic          last_winner;
  logic          tie_pick;
  logic          winner;

  logic          gnt0_q;
  logic          gnt1_q;
  logic          done0_q;
  logic          done1_q;
  logic [DW-1:0] rdata_q;
  logic          sel_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on ties: the port that did not win last time goes next.
  assign tie_pick = ~last_winner;
`else
  // Fixed priority to the data port. last_winner is still tracked, so the
  // expression references it, but the OR forces the result to port 1.
  assign tie_pick = last_winner | 1'b1;
`endif

  // Pick a winner from the current requests. A lone requester always wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = tie_pick;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  // Single-process control FSM with registered outputs. Requests are only
  // looked at in IDLE, and completions are only looked at in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel_q       <= winner;
            last_winner <= winner;
            mem_req_q   <= 1'b1;
            state       <= BUSY;
            if (winner) begin
              mem_addr_q  <= bus.addr1;
              mem_we_q    <= bus.we1;
              mem_wdata_q <= bus.wdata1;
              gnt1_q      <= 1'b1;
            end else begin
              // Fetch port is read-only: no store data to carry.
              mem_addr_q  <= bus.addr0;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              gnt0_q      <= 1'b1;
            end
          end
        end
        BUSY: begin
          // rdata is loaded for stores too. The requester ignores it then.
          if (bus.mem_ready) begin
            rdata_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            state     <= IDLE;
            if (sel_q) begin
              done1_q <= 1'b1;
            end else begin
              done0_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.sel       = sel_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus pushes the expected grant
// and completion records. The monitor pops and compares them whenever the DUT
// pulses gnt or done.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_g(input logic p, input logic [31:0] a, input logic w, input logic [31:0] d);
    gexp_t e;
    e.port = p; e.addr = a; e.we = w; e.wdata = d;
    gq.push_back(e);
  endtask

  task automatic push_d(input logic p, input logic [31:0] d);
    dexp_t e;
    e.port = p; e.data = d;
    dq.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt0"},      bus.gnt0,      0);
    chk({tag, "_gnt1"},      bus.gnt1,      0);
    chk({tag, "_done0"},     bus.done0,     0);
    chk({tag, "_done1"},     bus.done1,     0);
    chk({tag, "_rdata"},     bus.rdata,     0);
    chk({tag, "_sel"},       bus.sel,       0);
    chk({tag, "_mem_req"},   bus.mem_req,   0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_we"},    bus.mem_we,    0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // Wait (bounded) for mem_req, let waitc extra cycles pass, then give a one-cycle mem_ready.
  task automatic mem_respond(input int waitc, input logic [31:0] d);
    int guard = 0;
    while (bus.mem_req !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("mem_req_seen", bus.mem_req, 1);
    repeat (waitc) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = d;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Monitor: compare every grant and completion pulse against the scoreboard.
  always @(negedge clk) begin
    gexp_t ge;
    dexp_t de;
    if (rst_n) begin
      if (bus.gnt0 || bus.gnt1) begin
        chk("gnt_one_hot", bus.gnt0 & bus.gnt1, 0);
        chk("gnt_expected", gq.size() != 0, 1);
        if (gq.size() != 0) begin
          ge = gq.pop_front();
          chk("gnt_port",  bus.gnt1,      ge.port);
          chk("gnt_sel",   bus.sel,       ge.port);
          chk("gnt_req",   bus.mem_req,   1);
          chk("gnt_addr",  bus.mem_addr,  ge.addr);
          chk("gnt_we",    bus.mem_we,    ge.we);
          chk("gnt_wdata", bus.mem_wdata, ge.wdata);
        end
      end
      if (bus.done0 || bus.done1) begin
        chk("done_one_hot", bus.done0 & bus.done1, 0);
        chk("done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          de = dq.pop_front();
          chk("done_port",  bus.done1, de.port);
          chk("done_rdata", bus.rdata, de.data);
          chk("done_req_low", bus.mem_req, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req0      = 1'b0;
    bus.addr0     = '0;
    bus.req1      = 1'b0;
    bus.addr1     = '0;
    bus.we1       = 1'b0;
    bus.wdata1    = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check_all_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start a port-1 transaction, then pull reset while BUSY.
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.addr1 = 32'h0000_2000; bus.we1 = 1'b0; bus.wdata1 = '0;
    push_g(1'b1, 32'h0000_2000, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    @(posedge clk); #3;
    chk("busy_before_reset", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2;
    rst_n = 1'b1;

    // Fetch alone after reset: port 0 wins.
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.addr0 = 32'h0040_0000;
    push_g(1'b0, 32'h0040_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    push_d(1'b0, 32'hCAFE_0001);
    mem_respond(0, 32'hCAFE_0001);

    // Single load on port 1, memory answers a few cycles late.
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.addr1 = 32'h1001_0004; bus.we1 = 1'b0; bus.wdata1 = '0;
    push_g(1'b1, 32'h1001_0004, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    push_d(1'b1, 32'hDEAD_BEEF);
    mem_respond(3, 32'hDEAD_BEEF);

    // Spurious mem_ready while IDLE: nothing may happen.
    @(posedge clk); #1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9999_9999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ready_done0", bus.done0, 0);
      chk("idle_ready_done1", bus.done1, 0);
      chk("idle_ready_req",   bus.mem_req, 0);
      chk("idle_ready_rdata", bus.rdata, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    // Store on port 1 with the requester fields churning while BUSY.
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.addr1 = 32'h1001_0008; bus.we1 = 1'b1; bus.wdata1 = 32'h1234_5678;
    push_g(1'b1, 32'h1001_0008, 1'b1, 32'h1234_5678);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.addr1  = 32'hA000_0000 + i;
      bus.wdata1 = 32'h5000_0000 + i;
      bus.we1    = i[0];
      @(negedge clk);
      chk("store_addr_stable",  bus.mem_addr,  32'h1001_0008);
      chk("store_wdata_stable", bus.mem_wdata, 32'h1234_5678);
      chk("store_we_stable",    bus.mem_we,    1);
      chk("store_sel_stable",   bus.sel,       1);
      chk("store_req_stable",   bus.mem_req,   1);
      @(posedge clk); #1;
    end
    push_d(1'b1, 32'h55AA_55AA);
    mem_respond(0, 32'h55AA_55AA);
    @(negedge clk);
    chk("sel_held_idle", bus.sel, 1);

    // Fetch request that drops during a port-1 transaction is discarded.
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.addr1 = 32'h1001_0020; bus.we1 = 1'b0; bus.wdata1 = '0;
    push_g(1'b1, 32'h1001_0020, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h0040_0020;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    push_d(1'b1, 32'h0BAD_F00D);
    mem_respond(1, 32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dropped_no_gnt0", bus.gnt0, 0);
      chk("dropped_no_req",  bus.mem_req, 0);
    end

    // Both ports held high through four zero-wait transactions.
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.addr0 = 32'h0040_0010;
    bus.req1 = 1'b1; bus.addr1 = 32'h1001_0010; bus.we1 = 1'b0; bus.wdata1 = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i[0] == 1'b0) push_g(1'b0, 32'h0040_0010, 1'b0, 32'h0);
      else              push_g(1'b1, 32'h1001_0010, 1'b0, 32'h0);
      push_d(i[0], 32'h7700_0000 + i);
`else
      push_g(1'b1, 32'h1001_0010, 1'b0, 32'h0);
      push_d(1'b1, 32'h7700_0000 + i);
`endif
      @(posedge clk); #1;
      mem_respond(0, 32'h7700_0000 + i);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("gnt_queue_drained",  gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    chk("final_idle_req",     bus.mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
